// File: rtl/pe_south_link_arbiter.sv
// Round-robin arbiter sharing one south-bound PE link among NUM_REQ page engines.
// Locks onto one requester per packet, forwards beats through a single output register.
module pe_south_link_arbiter #(
    parameter int DATA_WIDTH = 130,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ap_start,
    input  logic [NUM_REQ-1:0]            in_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]            in_last,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    // Handshake: a beat moves on in_valid[g] & in_ready[g]; out side moves on out_valid & out_ready.
    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state;
    logic [CW-1:0]         idle_cnt;
    logic                  can_load;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;
    logic                  found;
    logic [GW-1:0]         next_id;

    assign can_load = ap_start & (~out_valid | out_ready);

    always_comb begin
        in_ready = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == GW'(i)) begin
                in_ready[i] = (state == GRANT) & can_load;
                sel_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last    = in_last[i];
            end
        end
    end

    assign xfer = |(in_valid & in_ready);

    // Cyclic search starting just after the previous grantee.
    always_comb begin
        found   = 1'b0;
        next_id = grant_id;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && in_valid[(int'(grant_id) + k) % NUM_REQ]) begin
                found   = 1'b1;
                next_id = GW'((int'(grant_id) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idle_cnt    <= '0;
            grant_id    <= GW'(NUM_REQ - 1);
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
        end else begin
            timeout_err <= 1'b0;

            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ap_start && found) begin
                        grant_id <= next_id;
                        state    <= GRANT;
                        busy     <= 1'b1;
                        idle_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        idle_cnt <= '0;
                        if (sel_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (ap_start) begin
                        // Revoke without inserting out_last; the partial packet stays open.
                        if (idle_cnt == CW'(TIMEOUT - 1)) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            timeout_err <= 1'b1;
                            idle_cnt    <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_south_link_arbiter.sv
// Directed bench for pe_south_link_arbiter: reset, packets, fairness, backpressure,
// timeout, ap_start freeze and asynchronous reset mid-packet.
module tb_pe_south_link_arbiter;

    localparam int DW = 130;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ap_start;
    logic [NR-1:0] in_valid;
    logic [DW-1:0] d [NR];
    logic [NR-1:0] in_last;
    logic [NR-1:0] in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic [1:0]    grant_id;
    logic          busy;
    logic          timeout_err;
    logic [NR*DW-1:0] in_data;

    int total = 0;
    int bad   = 0;

    assign in_data = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    pe_south_link_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mk(input int r, input int n);
        return {2'b10, r[31:0], 32'hdead_0000 + n[31:0], 64'(r * 100 + n)};
    endfunction

    task automatic offer(input int r, input logic v, input logic [DW-1:0] data, input logic l);
        in_valid[r] = v;
        d[r]        = data;
        in_last[r]  = l;
    endtask

    task automatic idle_inputs();
        in_valid = '0;
        in_last  = '0;
        for (int i = 0; i < NR; i++) d[i] = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ov"},  256'(out_valid),   256'(0));
        check({tag, "_od"},  256'(out_data),    256'(0));
        check({tag, "_ol"},  256'(out_last),    256'(0));
        check({tag, "_bsy"}, 256'(busy),        256'(0));
        check({tag, "_to"},  256'(timeout_err), 256'(0));
        check({tag, "_gid"}, 256'(grant_id),    256'(3));
        check({tag, "_rdy"}, 256'(in_ready),    256'(0));
    endtask

    initial begin
        reset = 1'b0; ap_start = 1'b0; out_ready = 1'b0;
        idle_inputs();

        // Reset held with random activity on the inputs.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ap_start  = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 4'($urandom_range(0, 15));
            in_last   = 4'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) d[i] = {2'b01, 64'($urandom), 64'($urandom)};
            #1;
            check_reset_outputs("rst_hold");
        end
        @(negedge clk);
        idle_inputs();
        out_ready = 1'b1;
        reset     = 1'b1;
        tick();

        // Single 3-beat packet from requester 1.
        offer(1, 1'b1, mk(1, 0), 1'b0);
        #1 check("sp_rdy_idle", 256'(in_ready), 256'(0));
        tick();
        check("sp_gid", 256'(grant_id), 256'(1));
        check("sp_bsy", 256'(busy), 256'(1));
        check("sp_rdy", 256'(in_ready), 256'(4'b0010));
        tick();
        offer(1, 1'b1, mk(1, 1), 1'b0);
        check("sp_a", 256'(out_data), 256'(mk(1, 0)));
        check("sp_a_l", 256'(out_last), 256'(0));
        tick();
        offer(1, 1'b1, mk(1, 2), 1'b1);
        check("sp_b", 256'(out_data), 256'(mk(1, 1)));
        check("sp_b_l", 256'(out_last), 256'(0));
        tick();
        idle_inputs();
        check("sp_c", 256'(out_data), 256'(mk(1, 2)));
        check("sp_c_l", 256'(out_last), 256'(1));
        check("sp_done_bsy", 256'(busy), 256'(0));
        check("sp_keep_gid", 256'(grant_id), 256'(1));
        tick();
        check("sp_drain", 256'(out_valid), 256'(0));

        // Fairness from a fresh reset: grant order 0,1,2,3,0,1 with a dead cycle each.
        reset = 1'b0;
        #3 reset = 1'b1;
        for (int i = 0; i < NR; i++) offer(i, 1'b1, mk(i, 7), 1'b1);
        for (int p = 0; p < 6; p++) begin
            tick();
            check("fair_gid", 256'(grant_id), 256'(p % 4));
            check("fair_bsy", 256'(busy), 256'(1));
            tick();
            check("fair_data", 256'(out_data), 256'(mk(p % 4, 7)));
            check("fair_dead", 256'(busy), 256'(0));
        end
        idle_inputs();
        tick();

        // Backpressure: 5 stall cycles between beat 0 and beat 1 of a 4-beat packet.
        offer(3, 1'b1, mk(3, 0), 1'b0);
        tick();
        check("bp_gid", 256'(grant_id), 256'(3));
        tick();
        offer(3, 1'b1, mk(3, 1), 1'b0);
        out_ready = 1'b0;
        #1 check("bp_rdy0", 256'(in_ready), 256'(0));
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_v", 256'(out_valid), 256'(1));
            check("bp_hold_d", 256'(out_data), 256'(mk(3, 0)));
            check("bp_hold_r", 256'(in_ready), 256'(0));
        end
        out_ready = 1'b1;
        #1 check("bp_rdy1", 256'(in_ready), 256'(4'b1000));
        tick();
        offer(3, 1'b1, mk(3, 2), 1'b0);
        check("bp_b1", 256'(out_data), 256'(mk(3, 1)));
        tick();
        offer(3, 1'b1, mk(3, 3), 1'b1);
        check("bp_b2", 256'(out_data), 256'(mk(3, 2)));
        tick();
        idle_inputs();
        check("bp_b3", 256'(out_data), 256'(mk(3, 3)));
        check("bp_b3_l", 256'(out_last), 256'(1));
        tick();
        check("bp_drain", 256'(out_valid), 256'(0));

        // Timeout: requester 2 sends one non-last beat then goes quiet.
        offer(2, 1'b1, mk(2, 0), 1'b0);
        tick();
        check("to_gid", 256'(grant_id), 256'(2));
        tick();
        idle_inputs();
        offer(3, 1'b1, mk(3, 9), 1'b1);
        check("to_beat", 256'(out_data), 256'(mk(2, 0)));
        for (int c = 1; c < 16; c++) begin
            tick();
            check("to_early", 256'(timeout_err), 256'(0));
            check("to_bsy", 256'(busy), 256'(1));
        end
        tick();
        check("to_pulse", 256'(timeout_err), 256'(1));
        check("to_bsy0", 256'(busy), 256'(0));
        check("to_nolast", 256'(out_last), 256'(0));
        tick();
        check("to_pulse_end", 256'(timeout_err), 256'(0));
        check("to_next_gid", 256'(grant_id), 256'(3));
        tick();
        idle_inputs();
        check("to_next_data", 256'(out_data), 256'(mk(3, 9)));
        tick();

        // A transfer on the cycle the counter would reach the limit prevents the revoke.
        offer(0, 1'b1, mk(0, 0), 1'b0);
        tick();
        check("edge_gid", 256'(grant_id), 256'(0));
        tick();
        idle_inputs();
        for (int c = 1; c < 16; c++) tick();
        offer(0, 1'b1, mk(0, 1), 1'b1);
        tick();
        idle_inputs();
        check("edge_no_to", 256'(timeout_err), 256'(0));
        check("edge_data", 256'(out_data), 256'(mk(0, 1)));
        check("edge_last", 256'(out_last), 256'(1));
        tick();

        // ap_start drop: 10 idle cycles, then 10 frozen cycles, then resume.
        offer(1, 1'b1, mk(1, 0), 1'b0);
        tick();
        check("ap_gid", 256'(grant_id), 256'(1));
        tick();
        idle_inputs();
        for (int c = 0; c < 10; c++) tick();
        ap_start = 1'b0;
        offer(1, 1'b1, mk(1, 1), 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("ap_no_to", 256'(timeout_err), 256'(0));
            check("ap_bsy", 256'(busy), 256'(1));
            check("ap_rdy0", 256'(in_ready), 256'(0));
            check("ap_drained", 256'(out_valid), 256'(0));
        end
        ap_start = 1'b1;
        #1 check("ap_rdy1", 256'(in_ready), 256'(4'b0010));
        check("ap_same_gid", 256'(grant_id), 256'(1));
        tick();
        offer(1, 1'b1, mk(1, 2), 1'b1);
        check("ap_b1", 256'(out_data), 256'(mk(1, 1)));
        check("ap_no_to2", 256'(timeout_err), 256'(0));
        tick();
        idle_inputs();
        check("ap_b2", 256'(out_data), 256'(mk(1, 2)));
        check("ap_b2_l", 256'(out_last), 256'(1));
        tick();

        // Asynchronous reset with a beat parked in the output register.
        offer(2, 1'b1, mk(2, 5), 1'b0);
        tick();
        check("ar_gid", 256'(grant_id), 256'(2));
        tick();
        out_ready = 1'b0;
        #1 check("ar_parked", 256'(out_valid), 256'(1));
        #2 reset = 1'b0;
        #1 check_reset_outputs("rst_async");
        tick();
        check_reset_outputs("rst_async_hold");
        idle_inputs();
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
